// File: rtl/march_bist_ctrl_pkg.sv
// Shared definitions for the March C- BIST controller: defaults, FSM states
// and the per-element march table.
package march_bist_ctrl_pkg;

    localparam int ADDR_WIDTH_DEF = 8;
    localparam int WORD_WIDTH_DEF = 4;
    localparam int NUM_ELEMS      = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic two_ops;
        logic descending;
        logic op0_write;
        logic op0_pol;
        logic op1_write;
        logic op1_pol;
    } elem_cfg_t;

    // March C-: up(w0) up(r0,w1) up(r1,w0) down(r0,w1) down(r1,w0) up(r0)
    function automatic elem_cfg_t elem_cfg(input logic [2:0] elem);
        elem_cfg_t cfg;
        cfg = '{two_ops: 1'b0, descending: 1'b0, op0_write: 1'b1,
                op0_pol: 1'b0, op1_write: 1'b0, op1_pol: 1'b0};
        case (elem)
            3'd1: cfg = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
            3'd2: cfg = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
            3'd3: cfg = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
            3'd4: cfg = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
            3'd5: cfg = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
            default: cfg = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        endcase
        return cfg;
    endfunction

endpackage

// File: rtl/march_bist_ctrl_if.sv
// SRAM-side port bundle of the BIST controller; master is the BIST sequencer,
// slave is the SRAM (through its functional/BIST muxes).
interface march_bist_ctrl_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int WORD_WIDTH = 4
) ();
    logic                  bist_sel;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [WORD_WIDTH-1:0] sram_din;
    logic                  sram_we;
    logic [WORD_WIDTH-1:0] sram_dout;

    modport master (
        output bist_sel, sram_addr, sram_din, sram_we,
        input  sram_dout
    );

    modport slave (
        input  bist_sel, sram_addr, sram_din, sram_we,
        output sram_dout
    );
endinterface

// File: rtl/march_elem_decode.sv
// Combinational lookup of the march table: what the current (element, op)
// pair does, and whether it is the last op at an address.
module march_elem_decode
    import march_bist_ctrl_pkg::*;
(
    input  logic [2:0] elem,
    input  logic       op_idx,
    output logic       is_write,
    output logic       polarity,
    output logic       descending,
    output logic       last_op
);

    elem_cfg_t cfg;

    always_comb begin
        cfg        = elem_cfg(elem);
        is_write   = op_idx ? cfg.op1_write : cfg.op0_write;
        polarity   = op_idx ? cfg.op1_pol   : cfg.op0_pol;
        descending = cfg.descending;
        last_op    = op_idx || !cfg.two_ops;
    end

endmodule

// File: rtl/march_bist_ctrl.sv
// March C- BIST sequencer: walks the SRAM one operation per cycle and checks
// read data through a one-stage compare pipeline.
module march_bist_ctrl
    import march_bist_ctrl_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = ADDR_WIDTH_DEF,
    parameter int                    WORD_WIDTH     = WORD_WIDTH_DEF,
    parameter logic [WORD_WIDTH-1:0] BG_PATTERN     = '0,
    parameter int                    FAIL_CNT_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    march_bist_ctrl_if.master         sram,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic                      fail,
    output logic [ADDR_WIDTH-1:0]     fail_addr,
    output logic [ADDR_WIDTH-1:0]     first_fail_addr,
    output logic [FAIL_CNT_WIDTH-1:0] fail_count,
    output logic [2:0]                cur_elem
);

    state_t                state, state_nxt;
    logic [2:0]            elem_q;
    logic                  op_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic                  drain_q;

    logic                  is_write, polarity, descending, last_op;
    logic                  idx_end, last_elem, run_last, start_run;
    logic [ADDR_WIDTH-1:0] op_addr;
    logic [WORD_WIDTH-1:0] op_data;

    logic                  cmp_valid;
    logic [ADDR_WIDTH-1:0] cmp_addr;
    logic [WORD_WIDTH-1:0] cmp_exp;
    logic                  mismatch;

    march_elem_decode u_decode (
        .elem       (elem_q),
        .op_idx     (op_q),
        .is_write   (is_write),
        .polarity   (polarity),
        .descending (descending),
        .last_op    (last_op)
    );

    // The sweep index always counts up; descending elements see it inverted,
    // so every element simply reloads the index to zero on entry.
    assign op_addr   = descending ? ~idx_q : idx_q;
    assign op_data   = polarity ? ~BG_PATTERN : BG_PATTERN;
    assign idx_end   = (idx_q == '1);
    assign last_elem = (elem_q == 3'(NUM_ELEMS - 1));
    assign run_last  = last_op && idx_end && last_elem;
    assign start_run = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign mismatch  = cmp_valid && (sram.sram_dout != cmp_exp);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        busy           = 1'b0;
        done           = 1'b0;
        pass           = 1'b0;
        cur_elem       = elem_q;
        sram.bist_sel  = 1'b0;
        sram.sram_we   = 1'b0;
        sram.sram_addr = '0;
        sram.sram_din  = '0;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_RUN;
            ST_RUN: begin
                if (run_last) state_nxt = ST_DRAIN;
                busy           = 1'b1;
                sram.bist_sel  = 1'b1;
                sram.sram_we   = is_write;
                sram.sram_addr = op_addr;
                sram.sram_din  = op_data;
            end
            ST_DRAIN: begin
                if (drain_q) state_nxt = ST_DONE;
                busy          = 1'b1;
                sram.bist_sel = 1'b1;
            end
            ST_DONE: begin
                if (start) state_nxt = ST_RUN;
                done = 1'b1;
                pass = (fail_count == '0);
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || start_run) begin
            elem_q  <= '0;
            op_q    <= 1'b0;
            idx_q   <= '0;
            drain_q <= 1'b0;
        end else if (state == ST_RUN) begin
            if (!last_op) begin
                op_q <= 1'b1;
            end else begin
                op_q  <= 1'b0;
                idx_q <= idx_q + 1'b1;
                if (idx_end && !last_elem) elem_q <= elem_q + 3'd1;
            end
        end else if (state == ST_DRAIN) begin
            drain_q <= 1'b1;
        end
    end

    // The compare keeps running through DRAIN so the last reads still count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_valid       <= 1'b0;
            cmp_addr        <= '0;
            cmp_exp         <= '0;
            fail            <= 1'b0;
            fail_addr       <= '0;
            first_fail_addr <= '0;
            fail_count      <= '0;
        end else begin
            cmp_valid <= (state == ST_RUN) && !is_write;
            cmp_addr  <= op_addr;
            cmp_exp   <= op_data;
            fail      <= mismatch;
            if (mismatch) fail_addr <= cmp_addr;
            if (start_run) begin
                fail_count      <= '0;
                first_fail_addr <= '0;
            end else if (mismatch) begin
                if (fail_count != '1) fail_count <= fail_count + 1'b1;
                if (fail_count == '0) first_fail_addr <= cmp_addr;
            end
        end
    end

endmodule

// File: tb/tb_march_bist_ctrl.sv
// Directed bench for march_bist_ctrl: fault-free runs, injected stuck faults,
// counter saturation, ignored start and mid-run reset.
module tb_march_bist_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic start_sat = 1'b0;
    int   fault_mode = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    march_bist_ctrl_if #(.ADDR_WIDTH(8), .WORD_WIDTH(4)) sa ();
    march_bist_ctrl_if #(.ADDR_WIDTH(8), .WORD_WIDTH(4)) sb ();

    logic       busy, done, pass, fail;
    logic [7:0] fail_addr, first_fail_addr, fail_count;
    logic [2:0] cur_elem;
    logic       busy_s, done_s, pass_s, fail_s;
    logic [7:0] fail_addr_s, first_fail_addr_s;
    logic [1:0] fail_count_s;
    logic [2:0] cur_elem_s;

    march_bist_ctrl #(.ADDR_WIDTH(8), .WORD_WIDTH(4), .BG_PATTERN(4'b0000), .FAIL_CNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .sram(sa.master),
        .busy(busy), .done(done), .pass(pass), .fail(fail),
        .fail_addr(fail_addr), .first_fail_addr(first_fail_addr),
        .fail_count(fail_count), .cur_elem(cur_elem)
    );

    march_bist_ctrl #(.ADDR_WIDTH(8), .WORD_WIDTH(4), .BG_PATTERN(4'b0000), .FAIL_CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst(rst), .start(start_sat), .sram(sb.master),
        .busy(busy_s), .done(done_s), .pass(pass_s), .fail(fail_s),
        .fail_addr(fail_addr_s), .first_fail_addr(first_fail_addr_s),
        .fail_count(fail_count_s), .cur_elem(cur_elem_s)
    );

    // SRAM models: registered read; A optionally has bit0 of 0x3C stuck at 1,
    // B always has 0x10 and 0x20 stuck at 0000.
    logic [3:0] mem_a [256];
    logic [3:0] mem_b [256];
    logic [3:0] dout_a, dout_b;

    always @(posedge clk) begin
        if (sa.sram_we) mem_a[sa.sram_addr] <= sa.sram_din;
        if (fault_mode == 1 && sa.sram_addr == 8'h3C) dout_a <= mem_a[sa.sram_addr] | 4'b0001;
        else                                           dout_a <= mem_a[sa.sram_addr];
        if (sb.sram_we) mem_b[sb.sram_addr] <= sb.sram_din;
        if (sb.sram_addr == 8'h10 || sb.sram_addr == 8'h20) dout_b <= 4'b0000;
        else                                                 dout_b <= mem_b[sb.sram_addr];
    end

    assign sa.sram_dout = dout_a;
    assign sb.sram_dout = dout_b;

    // Reference sequence of {we, addr, din} for operation index k.
    function automatic logic [12:0] exp_op(input int k);
        int r, e, i;
        logic we, pol;
        logic [7:0] a;
        if (k < 256)   return {1'b1, 8'(k), 4'h0};
        if (k >= 2304) return {1'b0, 8'(k - 2304), 4'h0};
        r   = k - 256;
        e   = r / 512 + 1;
        i   = (r % 512) / 2;
        we  = (r % 2) == 1;
        a   = (e == 3 || e == 4) ? 8'(255 - i) : 8'(i);
        pol = (e == 1 || e == 3) ? we : !we;
        return {we, a, pol ? 4'hF : 4'h0};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Leaves the caller one time step after E0, i.e. in the cycle of op 0.
    task automatic do_start(input bit sat);
        step(1);
        if (sat) start_sat = 1'b1;
        else     start = 1'b1;
        step(1);
        start = 1'b0;
        start_sat = 1'b0;
    endtask

    task automatic test_reset();
        logic [44:0] obs_a;
        logic [38:0] obs_b;
        rst = 1'b1;
        step(3);
        obs_a = {busy, done, pass, fail, fail_addr, first_fail_addr, fail_count, cur_elem,
                 sa.bist_sel, sa.sram_we, sa.sram_addr, sa.sram_din};
        obs_b = {busy_s, done_s, pass_s, fail_s, fail_addr_s, first_fail_addr_s, fail_count_s,
                 cur_elem_s, sb.bist_sel, sb.sram_we, sb.sram_addr, sb.sram_din};
        n_checks++;
        if (obs_a !== 45'd0) begin n_fail++; $display("[TB] FAIL reset_outputs: got %h expected 0", obs_a); end
        n_checks++;
        if (obs_b !== 39'd0) begin n_fail++; $display("[TB] FAIL reset_outputs_sat: got %h expected 0", obs_b); end
        rst = 1'b0;
        step(2);
        n_checks++;
        if ({busy, done} !== 2'b00) begin n_fail++; $display("[TB] FAIL idle_after_reset: got %b expected 00", {busy, done}); end
    endtask

    task automatic test_fault_free();
        int writes = 0, reads = 0, fails = 0;
        fault_mode = 0;
        do_start(0);
        n_checks++;
        if ({sa.sram_we, sa.sram_addr, sa.sram_din, busy, sa.bist_sel} !== {1'b1, 8'h00, 4'h0, 2'b11}) begin
            n_fail++;
            $display("[TB] FAIL first_op: got %h expected %h",
                     {sa.sram_we, sa.sram_addr, sa.sram_din, busy, sa.bist_sel}, {1'b1, 8'h00, 4'h0, 2'b11});
        end
        for (int k = 0; k < 2562; k++) begin
            if (k < 2560) begin
                if (sa.sram_we) writes++;
                else            reads++;
            end
            if (fail) fails++;
            if (k == 2561) begin
                n_checks++;
                if ({busy, done} !== 2'b10) begin n_fail++; $display("[TB] FAIL drain_busy: got %b expected 10", {busy, done}); end
            end
            step(1);
        end
        if (fail) fails++;
        n_checks++;
        if ({writes, reads} !== {32'd1280, 32'd1280}) begin
            n_fail++;
            $display("[TB] FAIL op_counts: got w=%0d r=%0d expected w=1280 r=1280", writes, reads);
        end
        n_checks++;
        if (fails !== 0) begin n_fail++; $display("[TB] FAIL no_fail_pulse: got %0d expected 0", fails); end
        n_checks++;
        if ({done, busy, pass, sa.bist_sel, sa.sram_we, fail_count} !== {5'b10100, 8'd0}) begin
            n_fail++;
            $display("[TB] FAIL done_pass: got %h expected %h",
                     {done, busy, pass, sa.bist_sel, sa.sram_we, fail_count}, {5'b10100, 8'd0});
        end
    endtask

    task automatic test_direction();
        logic [15:0] exp_v;
        bit chk;
        fault_mode = 0;
        do_start(0);
        for (int k = 0; k < 2562; k++) begin
            chk = 1'b1;
            exp_v = '0;
            case (k)
                256:     exp_v = {3'd1, 1'b0, 8'h00, 4'h0};
                1280:    exp_v = {3'd3, 1'b0, 8'hFF, 4'h0};
                1281:    exp_v = {3'd3, 1'b1, 8'hFF, 4'hF};
                1282:    exp_v = {3'd3, 1'b0, 8'hFE, 4'h0};
                1792:    exp_v = {3'd4, 1'b0, 8'hFF, 4'hF};
                2304:    exp_v = {3'd5, 1'b0, 8'h00, 4'h0};
                2559:    exp_v = {3'd5, 1'b0, 8'hFF, 4'h0};
                default: chk = 1'b0;
            endcase
            if (chk) begin
                n_checks++;
                if ({cur_elem, sa.sram_we, sa.sram_addr, sa.sram_din} !== exp_v) begin
                    n_fail++;
                    $display("[TB] FAIL direction k=%0d: got %h expected %h", k,
                             {cur_elem, sa.sram_we, sa.sram_addr, sa.sram_din}, exp_v);
                end
            end
            step(1);
        end
        n_checks++;
        if ({done, pass} !== 2'b11) begin n_fail++; $display("[TB] FAIL direction_done: got %b expected 11", {done, pass}); end
    endtask

    task automatic test_stuck_bit();
        int nf = 0;
        int fk [3];
        logic [7:0] fa [3];
        int exp_k [3] = '{378, 1672, 2366};
        fault_mode = 1;
        do_start(0);
        for (int k = 0; k < 2562; k++) begin
            if (fail) begin
                if (nf < 3) begin fk[nf] = k; fa[nf] = fail_addr; end
                nf++;
            end
            step(1);
        end
        n_checks++;
        if (nf !== 3) begin n_fail++; $display("[TB] FAIL stuck_pulses: got %0d expected 3", nf); end
        for (int i = 0; i < 3 && i < nf; i++) begin
            n_checks++;
            if (fk[i] !== exp_k[i] || fa[i] !== 8'h3C) begin
                n_fail++;
                $display("[TB] FAIL stuck_pulse%0d: got k=%0d addr=%h expected k=%0d addr=3c", i, fk[i], fa[i], exp_k[i]);
            end
        end
        n_checks++;
        if ({done, pass, fail_count, first_fail_addr} !== {2'b10, 8'd3, 8'h3C}) begin
            n_fail++;
            $display("[TB] FAIL stuck_summary: got %h expected %h",
                     {done, pass, fail_count, first_fail_addr}, {2'b10, 8'd3, 8'h3C});
        end
    endtask

    task automatic test_start_ignored();
        int seq_bad = 0;
        fault_mode = 0;
        do_start(0);
        n_checks++;
        if ({done, pass, fail_count, first_fail_addr, busy} !== {2'b00, 16'd0, 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL restart_clears: got %h expected %h",
                     {done, pass, fail_count, first_fail_addr, busy}, {2'b00, 16'd0, 1'b1});
        end
        for (int k = 0; k < 2562; k++) begin
            if (k < 2560 && {sa.sram_we, sa.sram_addr, sa.sram_din} !== exp_op(k)) seq_bad++;
            if (k == 2561) begin
                n_checks++;
                if ({busy, done} !== 2'b10) begin n_fail++; $display("[TB] FAIL restart_drain: got %b expected 10", {busy, done}); end
            end
            start = (k == 500);
            step(1);
        end
        start = 1'b0;
        n_checks++;
        if (seq_bad !== 0) begin n_fail++; $display("[TB] FAIL op_sequence: got %0d bad ops expected 0", seq_bad); end
        n_checks++;
        if ({busy, done, pass} !== 3'b011) begin n_fail++; $display("[TB] FAIL restart_done: got %b expected 011", {busy, done, pass}); end
    endtask

    task automatic test_saturation();
        int nf = 0;
        logic [31:0] addrs = '0;
        do_start(1);
        for (int k = 0; k < 2562; k++) begin
            if (fail_s) begin
                if (nf < 4) addrs = {addrs[23:0], fail_addr_s};
                nf++;
            end
            step(1);
        end
        n_checks++;
        if (nf !== 4) begin n_fail++; $display("[TB] FAIL sat_pulses: got %0d expected 4", nf); end
        n_checks++;
        if (addrs !== 32'h10202010) begin n_fail++; $display("[TB] FAIL sat_addrs: got %h expected 10202010", addrs); end
        n_checks++;
        if ({done_s, pass_s, fail_count_s, first_fail_addr_s} !== {2'b10, 2'd3, 8'h10}) begin
            n_fail++;
            $display("[TB] FAIL sat_summary: got %h expected %h",
                     {done_s, pass_s, fail_count_s, first_fail_addr_s}, {2'b10, 2'd3, 8'h10});
        end
    endtask

    task automatic test_reset_abort();
        fault_mode = 1;
        do_start(0);
        step(1000);
        n_checks++;
        if ({busy, fail_count} !== {1'b1, 8'd1}) begin
            n_fail++;
            $display("[TB] FAIL pre_abort: got %h expected %h", {busy, fail_count}, {1'b1, 8'd1});
        end
        rst = 1'b1;
        step(1);
        n_checks++;
        if ({busy, sa.bist_sel, sa.sram_we, fail_count, done, fail, cur_elem, sa.sram_addr} !== 23'd0) begin
            n_fail++;
            $display("[TB] FAIL abort_outputs: got %h expected 0",
                     {busy, sa.bist_sel, sa.sram_we, fail_count, done, fail, cur_elem, sa.sram_addr});
        end
        rst = 1'b0;
        step(2);
        n_checks++;
        if ({busy, fail} !== 2'b00) begin n_fail++; $display("[TB] FAIL abort_quiet: got %b expected 00", {busy, fail}); end
        fault_mode = 0;
        do_start(0);
        step(2562);
        n_checks++;
        if ({done, pass, fail_count, first_fail_addr} !== {2'b11, 16'd0}) begin
            n_fail++;
            $display("[TB] FAIL rerun_pass: got %h expected %h",
                     {done, pass, fail_count, first_fail_addr}, {2'b11, 16'd0});
        end
    endtask

    initial begin
        $display("[TB] march_bist_ctrl bench starting");
        test_reset();
        test_fault_free();
        test_direction();
        test_stuck_bit();
        test_start_ignored();
        test_saturation();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
